// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sseg_pkg;

    // Scan FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // One-hot-low anode vector for a digit index
    function automatic logic [3:0] an_onehot(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Signal bundle between the digit encoders and the scan controller.
// There is no valid/ready handshake: en is a level enable with no
// backpressure, and an/sseg/dp/slot_done/frame_done are free-running
// registered outputs valid on every cycle after reset.
interface sseg_scan_ctrl_if;
    import sseg_pkg::*;

    logic       en;
    logic [6:0] in0;
    logic [6:0] in1;
    logic [6:0] in2;
    logic [6:0] in3;
    logic [3:0] bright;
    logic [3:0] blink_mask;
    logic [3:0] dp_sel;
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dp;
    logic       slot_done;
    logic       frame_done;
    state_t     dbg_state;

    modport master (
        output en, in0, in1, in2, in3, bright, blink_mask, dp_sel,
        input  an, sseg, dp, slot_done, frame_done, dbg_state
    );

    modport slave (
        input  en, in0, in1, in2, in3, bright, blink_mask, dp_sel,
        output an, sseg, dp, slot_done, frame_done, dbg_state
    );

endinterface

// File: rtl/sseg_pwm_cmp.sv
// Brightness window compare: lit while the offset into the active part of
// the slot is below STEP*(bright+1). Offsets inside the dead time wrap to
// a large unsigned value and therefore never compare as lit.
module sseg_pwm_cmp #(
    parameter int unsigned SLOT_CYCLES = 100000,
    parameter int unsigned DEAD_CYCLES = 1000,
    parameter int unsigned CW          = 17
) (
    input  logic [CW-1:0] cnt,
    input  logic [3:0]    bright,
    output logic          lit_window
);

    localparam int unsigned ACTIVE = SLOT_CYCLES - DEAD_CYCLES;
    localparam int unsigned STEP   = ACTIVE / 16;

    logic [31:0] offset;
    logic [31:0] limit;

    // Offset into the active window versus the brightness limit
    always_comb begin
        offset     = 32'(cnt) - 32'(DEAD_CYCLES);
        limit      = 32'(STEP) * (32'(bright) + 32'd1);
        lit_window = (offset < limit);
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with dead-time
// blanking, PWM brightness, per-digit blink and decimal-point control.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES = 100000,
    parameter int unsigned DEAD_CYCLES = 1000,
    parameter int unsigned BLINK_SLOTS = 500
) (
    input  logic             clk,
    input  logic             reset_n,
    sseg_scan_ctrl_if.slave  bus
);

    localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    digit, digit_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          blink_phase, blink_phase_n;
    logic [6:0]    lat_seg, lat_seg_n;
    logic          lat_dp, lat_dp_n;
    logic [6:0]    sel_seg;
    logic          load;
    logic          slot_end;
    logic          lit_window;
    logic          lit;

    sseg_pwm_cmp #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .DEAD_CYCLES (DEAD_CYCLES),
        .CW          (CW)
    ) u_pwm_cmp (
        .cnt        (cnt),
        .bright     (bus.bright),
        .lit_window (lit_window)
    );

    assign bus.dbg_state = state;

    // Next-state logic: slot sequencing, value latching on DEAD entry, blink
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        digit_n       = digit;
        blink_cnt_n   = blink_cnt;
        blink_phase_n = blink_phase;
        lat_seg_n     = lat_seg;
        lat_dp_n      = lat_dp;
        load          = 1'b0;
        slot_end      = 1'b0;
        sel_seg       = SEG_BLANK;

        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_n = DEAD;
                    cnt_n   = '0;
                    digit_n = 2'd0;
                    load    = 1'b1;
                end
            end
            DEAD: begin
                if (!bus.en) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    digit_n = 2'd0;
                end else begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(DEAD_CYCLES - 1)) state_n = ON;
                end
            end
            ON: begin
                if (!bus.en) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    digit_n = 2'd0;
                end else if (cnt == CW'(SLOT_CYCLES - 1)) begin
                    state_n  = DEAD;
                    cnt_n    = '0;
                    digit_n  = digit + 2'd1;
                    load     = 1'b1;
                    slot_end = 1'b1;
                    if (blink_cnt == BW'(BLINK_SLOTS - 1)) begin
                        blink_cnt_n   = '0;
                        blink_phase_n = ~blink_phase;
                    end else begin
                        blink_cnt_n = blink_cnt + BW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                digit_n = 2'd0;
            end
        endcase

        case (digit_n)
            2'd0:    sel_seg = bus.in0;
            2'd1:    sel_seg = bus.in1;
            2'd2:    sel_seg = bus.in2;
            default: sel_seg = bus.in3;
        endcase

        if (load) begin
            lat_seg_n = sel_seg;
            lat_dp_n  = bus.dp_sel[digit_n];
        end
    end

    // Lit decision from current state; drives the registered pin outputs
    always_comb begin
        lit = (state == ON) && lit_window && !(blink_phase && bus.blink_mask[digit]);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            digit          <= 2'd0;
            blink_cnt      <= '0;
            blink_phase    <= 1'b0;
            lat_seg        <= SEG_BLANK;
            lat_dp         <= 1'b0;
            bus.an         <= AN_OFF;
            bus.sseg       <= SEG_BLANK;
            bus.dp         <= 1'b1;
            bus.slot_done  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            digit          <= digit_n;
            blink_cnt      <= blink_cnt_n;
            blink_phase    <= blink_phase_n;
            lat_seg        <= lat_seg_n;
            lat_dp         <= lat_dp_n;
            bus.an         <= lit ? an_onehot(digit) : AN_OFF;
            bus.sseg       <= lit ? lat_seg : SEG_BLANK;
            bus.dp         <= lit ? ~lat_dp : 1'b1;
            bus.slot_done  <= slot_end;
            bus.frame_done <= slot_end && (digit == 2'd3);
        end
    end

endmodule
